buffer2sram_weight: RTL and testbench

- Drains one half of the ping-pong weight buffer (2 x 128 x 288-bit) into the 32 weight SRAM banks. Each word goes to the bank/address slot the conv controller reads.
- Sits between the DMA, which fills the weight buffer from DRAM, and the weight SRAM write port, which is muxed by weight_SRAM_rw_select.
- transfer_controller starts it with a pulse and waits for done.

---
 rtl/buffer2sram_weight.sv | 132 +++++++++++++
 tb/tb_buffer2sram_weight.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/buffer2sram_weight.sv
// Drains one half of the ping-pong weight buffer into the banked weight SRAM,
// one word per cycle, mapping word i to bank (BANK_start+i) mod BANKS.
module buffer2sram_weight #(
  parameter int BANKS  = 32,
  parameter int WORD_W = 288,
  parameter int ADDR_W = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        BUF_ADDR_start,
  input  logic [ADDR_W-1:0]        BUF_ADDR_end,
  input  logic                     buf_select,
  input  logic [ADDR_W-1:0]        SRAM_ADDR_start,
  input  logic [$clog2(BANKS)-1:0] BANK_start,
  input  logic                     buffer2sram_start,
  output logic                     buffer2sram_done,
  input  logic [WORD_W-1:0]        weight_buffer_DO       [0:1],
  output logic                     weight_buffer_CEN_read [0:1],
  output logic                     weight_buffer_OEN      [0:1],
  output logic [ADDR_W-1:0]        weight_buffer_A_read   [0:1],
  output logic [WORD_W-1:0]        weight_SRAM_DI         [0:BANKS-1],
  output logic [ADDR_W-1:0]        weight_SRAM_A_write    [0:BANKS-1],
  output logic                     weight_SRAM_CEN_write  [0:BANKS-1],
  output logic                     weight_SRAM_WEN        [0:BANKS-1]
);

  localparam int BANK_W = $clog2(BANKS);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t              state;
  logic                sel_p0;
  logic [ADDR_W-1:0]   end_p0;
  logic [ADDR_W-1:0]   rd_addr_p0;
  logic [1:0]          rd_cen_p0;
  logic [1:0]          rd_oen_p0;
  logic [BANK_W-1:0]   bank_p0;
  logic [ADDR_W-1:0]   row_p0;
  logic [BANKS-1:0]    wr_sel_p1;
  logic [ADDR_W-1:0]   wr_row_p1;
  logic                vld_p1;
  logic                done_p2;

  function automatic logic [BANKS-1:0] bank_onehot(input logic [BANK_W-1:0] b);
    bank_onehot    = '0;
    bank_onehot[b] = 1'b1;
  endfunction

  // Active-low enable pair for the two buffer halves: only the chosen one is low.
  function automatic logic [1:0] half_enable_n(input logic sel);
    half_enable_n = sel ? 2'b01 : 2'b10;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      sel_p0     <= 1'b0;
      end_p0     <= '0;
      rd_addr_p0 <= '0;
      rd_cen_p0  <= 2'b11;
      rd_oen_p0  <= 2'b11;
      bank_p0    <= '0;
      row_p0     <= '0;
      wr_sel_p1  <= '0;
      wr_row_p1  <= '0;
      vld_p1     <= 1'b0;
      done_p2    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_p2   <= 1'b0;
          wr_sel_p1 <= '0;
          vld_p1    <= 1'b0;
          if (buffer2sram_start) begin
            state      <= READ;
            sel_p0     <= buf_select;
            end_p0     <= BUF_ADDR_end;
            rd_addr_p0 <= BUF_ADDR_start;
            bank_p0    <= BANK_start;
            row_p0     <= SRAM_ADDR_start;
            rd_cen_p0  <= half_enable_n(buf_select);
            rd_oen_p0  <= half_enable_n(buf_select);
          end
        end
        // p0 -> p1: the read issued this cycle becomes next cycle's bank write
        READ: begin
          wr_sel_p1 <= bank_onehot(bank_p0);
          wr_row_p1 <= row_p0;
          vld_p1    <= 1'b1;
          bank_p0   <= bank_p0 + BANK_W'(1);
          if (bank_p0 == '1) row_p0 <= row_p0 + ADDR_W'(1);
          if (rd_addr_p0 == end_p0) begin
            state     <= DRAIN;
            rd_cen_p0 <= 2'b11;
          end else begin
            rd_addr_p0 <= rd_addr_p0 + ADDR_W'(1);
          end
        end
        // p1 -> p2: final write retires, completion pulse follows
        DRAIN: begin
          wr_sel_p1 <= '0;
          vld_p1    <= 1'b0;
          rd_oen_p0 <= 2'b11;
          done_p2   <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          done_p2 <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign buffer2sram_done = done_p2;

  for (genvar h = 0; h < 2; h++) begin : g_buf
    assign weight_buffer_CEN_read[h] = rd_cen_p0[h];
    assign weight_buffer_OEN[h]      = rd_oen_p0[h];
    assign weight_buffer_A_read[h]   = rd_addr_p0;
  end

  // Buffer read data has one cycle of latency, so it lines up with the p1 write.
  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    assign weight_SRAM_DI[b]        = vld_p1 ? weight_buffer_DO[sel_p0] : '0;
    assign weight_SRAM_A_write[b]   = wr_row_p1;
    assign weight_SRAM_CEN_write[b] = ~wr_sel_p1[b];
    assign weight_SRAM_WEN[b]       = ~wr_sel_p1[b];
  end

endmodule

// File: tb/tb_buffer2sram_weight.sv
// Directed bench for buffer2sram_weight: buffer model plus per-cycle checks.
module tb_buffer2sram_weight;
  localparam int BANKS  = 32;
  localparam int WORD_W = 288;
  localparam int ADDR_W = 7;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] buf_addr_start = '0;
  logic [ADDR_W-1:0] buf_addr_end   = '0;
  logic              buf_select     = 1'b0;
  logic [ADDR_W-1:0] sram_addr_start = '0;
  logic [4:0]        bank_start     = '0;
  logic              start          = 1'b0;
  logic              done;
  logic [WORD_W-1:0] buf_do   [0:1];
  logic              buf_cen  [0:1];
  logic              buf_oen  [0:1];
  logic [ADDR_W-1:0] buf_a    [0:1];
  logic [WORD_W-1:0] sram_di  [0:BANKS-1];
  logic [ADDR_W-1:0] sram_a   [0:BANKS-1];
  logic              sram_cen [0:BANKS-1];
  logic              sram_wen [0:BANKS-1];
  logic [WORD_W-1:0] buf_q    [0:1];

  int passed = 0;
  int total  = 0;

  // change-during-READ configuration
  logic              chg_sel;
  logic [ADDR_W-1:0] chg_s, chg_e, chg_row;
  logic [4:0]        chg_bank;

  always #5 clk = ~clk;

  buffer2sram_weight dut (
    .clk(clk), .rst(rst),
    .BUF_ADDR_start(buf_addr_start), .BUF_ADDR_end(buf_addr_end),
    .buf_select(buf_select), .SRAM_ADDR_start(sram_addr_start),
    .BANK_start(bank_start), .buffer2sram_start(start),
    .buffer2sram_done(done),
    .weight_buffer_DO(buf_do), .weight_buffer_CEN_read(buf_cen),
    .weight_buffer_OEN(buf_oen), .weight_buffer_A_read(buf_a),
    .weight_SRAM_DI(sram_di), .weight_SRAM_A_write(sram_a),
    .weight_SRAM_CEN_write(sram_cen), .weight_SRAM_WEN(sram_wen)
  );

  function automatic logic [WORD_W-1:0] word(input int b, input int a);
    logic [31:0] t;
    t = {8'(b + 1), 8'(a), 16'hC35A};
    for (int k = 0; k < 9; k++) word[k*32 +: 32] = t ^ 32'(k * 32'h01010101);
  endfunction

  always @(posedge clk) begin
    for (int b = 0; b < 2; b++)
      if (!buf_cen[b]) buf_q[b] <= word(b, int'(buf_a[b]));
  end

  always_comb begin
    for (int b = 0; b < 2; b++) buf_do[b] = buf_oen[b] ? '0 : buf_q[b];
  end

  task automatic kick(input logic sel, input int s, input int e,
                      input int bk, input int row);
    @(negedge clk);
    buf_select      = sel;
    buf_addr_start  = ADDR_W'(s);
    buf_addr_end    = ADDR_W'(e);
    bank_start      = 5'(bk);
    sram_addr_start = ADDR_W'(row);
    start           = 1'b1;
    @(posedge clk);
  endtask

  // Called right after the accepting edge; checks cycles k+1 .. k+N+3.
  task automatic check_xfer(input string name, input logic sel, input int s,
                            input int e, input int bk, input int row,
                            input int abort_c, input bit hold, input bit chg);
    int n, i, sl, eb, er;
    logic [3:0]       rd_act, rd_exp;
    logic [BANKS-1:0] cen_act, wen_act, wr_exp;
    n = ((e - s + 128) % 128) + 1;
    for (int c = 1; c <= n + 3; c++) begin
      @(negedge clk);
      if (c == 1 && !hold) start = 1'b0;
      if (c == 2 && chg) begin
        buf_select = chg_sel; buf_addr_start = chg_s; buf_addr_end = chg_e;
        bank_start = chg_bank; sram_addr_start = chg_row;
      end
      rd_act = {buf_oen[1], buf_oen[0], buf_cen[1], buf_cen[0]};
      rd_exp = 4'b1111;
      if (c <= n)     rd_exp[sel ? 1 : 0] = 1'b0;
      if (c <= n + 1) rd_exp[sel ? 3 : 2] = 1'b0;
      total++;
      if (rd_act !== rd_exp)
        $display("FAIL %s rd_en c=%0d got %b want %b", name, c, rd_act, rd_exp);
      else passed++;
      if (c <= n) begin
        total++;
        if (buf_a[sel] !== ADDR_W'((s + c - 1) % 128))
          $display("FAIL %s rd_addr c=%0d got %0d want %0d", name, c,
                   buf_a[sel], (s + c - 1) % 128);
        else passed++;
      end
      for (int b = 0; b < BANKS; b++) begin
        cen_act[b] = sram_cen[b];
        wen_act[b] = sram_wen[b];
      end
      wr_exp = '1;
      eb = 0; er = 0; i = c - 2;
      if (c >= 2 && c <= n + 1) begin
        sl = bk + i;
        eb = sl % 32;
        er = (row + sl / 32) % 128;
        wr_exp[eb] = 1'b0;
      end
      total++;
      if (cen_act !== wr_exp || wen_act !== wr_exp)
        $display("FAIL %s wr_en c=%0d got cen %h wen %h want %h", name, c,
                 cen_act, wen_act, wr_exp);
      else passed++;
      if (c >= 2 && c <= n + 1) begin
        total++;
        if (sram_a[eb] !== ADDR_W'(er) ||
            sram_di[eb] !== word(sel, (s + i) % 128))
          $display("FAIL %s wr_data c=%0d bank %0d got row %0d di %h want row %0d di %h",
                   name, c, eb, sram_a[eb], sram_di[eb][31:0], er,
                   word(sel, (s + i) % 128) >> 0 & 288'hFFFFFFFF);
        else passed++;
      end
      total++;
      if (done !== (c == n + 2))
        $display("FAIL %s done c=%0d got %b want %b", name, c, done, (c == n + 2));
      else passed++;
      if (c == abort_c) begin
        #2 rst = 1'b0;
        #1;
        for (int b = 0; b < BANKS; b++) begin
          cen_act[b] = sram_cen[b];
          wen_act[b] = sram_wen[b];
        end
        total++;
        if (cen_act !== '1 || wen_act !== '1 || done !== 1'b0 ||
            {buf_oen[1], buf_oen[0], buf_cen[1], buf_cen[0]} !== 4'b1111 ||
            sram_di[0] !== '0)
          $display("FAIL %s async_abort got cen %h wen %h done %b", name,
                   cen_act, wen_act, done);
        else passed++;
        return;
      end
    end
  endtask

  task automatic test_reset();
    logic [BANKS-1:0] cen_act;
    rst = 1'b1;
    #3 rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int b = 0; b < BANKS; b++) cen_act[b] = sram_cen[b] & sram_wen[b];
    total++;
    if (cen_act !== '1 || done !== 1'b0 ||
        {buf_oen[1], buf_oen[0], buf_cen[1], buf_cen[0]} !== 4'b1111)
      $display("FAIL reset_enables got sram %h done %b", cen_act, done);
    else passed++;
    total++;
    if (buf_a[0] !== '0 || buf_a[1] !== '0 || sram_a[0] !== '0 || sram_di[5] !== '0)
      $display("FAIL reset_values got a_rd %0d/%0d a_wr %0d", buf_a[0], buf_a[1], sram_a[0]);
    else passed++;
    rst = 1'b1;
  endtask

  task automatic test_basic();
    kick(1'b0, 0, 3, 0, 5);
    check_xfer("basic", 1'b0, 0, 3, 0, 5, 0, 1'b0, 1'b0);
  endtask

  task automatic test_bank_wrap();
    kick(1'b1, 10, 13, 30, 2);
    check_xfer("bank_wrap", 1'b1, 10, 13, 30, 2, 0, 1'b0, 1'b0);
  endtask

  task automatic test_addr_wrap();
    kick(1'b0, 126, 1, 3, 7);
    check_xfer("addr_wrap", 1'b0, 126, 1, 3, 7, 0, 1'b0, 1'b0);
    kick(1'b1, 50, 50, 17, 100);
    check_xfer("single", 1'b1, 50, 50, 17, 100, 0, 1'b0, 1'b0);
  endtask

  task automatic test_full();
    kick(1'b0, 0, 127, 0, 0);
    check_xfer("full", 1'b0, 0, 127, 0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_mid_reset();
    kick(1'b1, 0, 19, 4, 20);
    check_xfer("mid_reset", 1'b1, 0, 19, 4, 20, 6, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      total++;
      if (done !== 1'b0 || buf_cen[1] !== 1'b1)
        $display("FAIL post_reset_idle c=%0d got done %b cen %b want 0 1", c, done, buf_cen[1]);
      else passed++;
    end
    kick(1'b0, 60, 62, 12, 33);
    check_xfer("after_reset", 1'b0, 60, 62, 12, 33, 0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    chg_sel = 1'b1; chg_s = 7'd40; chg_e = 7'd41; chg_bank = 5'd31; chg_row = 7'd127;
    kick(1'b0, 20, 22, 5, 9);
    check_xfer("held_first", 1'b0, 20, 22, 5, 9, 0, 1'b1, 1'b1);
    @(posedge clk);
    check_xfer("held_second", 1'b1, 40, 41, 31, 127, 0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bank_wrap();
    test_addr_wrap();
    test_full();
    test_mid_reset();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
